// File: rtl/common_fifo_pkg.sv
// Shared types and helpers for the common FIFO family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package common_fifo_pkg;

    // Default depth exponent for the shared status layout.
    // Each FIFO declares its own copy of this layout at its real DL.
    localparam int unsigned STAT_DL_DEF = 2;

    typedef struct packed {
        logic [STAT_DL_DEF:0] occ;
        logic [STAT_DL_DEF:0] free;
    } fifo_stat_t;

    // True when v is a non-zero power of two.
    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/common_regfile_mw.sv
// Multi-lane word register file: DWI write lanes at wp, DWO read lanes at rp.
// Latency: write visible on the next cycle; reads are combinational.
// Backpressure: none; the caller gates the write enable.
module common_regfile_mw #(
    parameter int unsigned DW  = 32,
    parameter int unsigned DWI = 1,
    parameter int unsigned DWO = 1,
    parameter int unsigned DL  = 2
) (
    input  logic              clk,
    input  logic              we,
    input  logic [DL-1:0]     wp,
    input  logic [DW*DWI-1:0] wdata,
    input  logic [DL-1:0]     rp,
    output logic [DW*DWO-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << DL;

    logic [DW-1:0] mem [DEPTH];

    // Write DWI consecutive words starting at wp; the index wraps naturally at DL bits.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < DWI; k++) begin
                mem[wp + DL'(k)] <= wdata[k*DW +: DW];
            end
        end
    end

    // Read DWO consecutive words starting at rp; lane 0 is the oldest word.
    always_comb begin
        rdata = '0;
        for (int k = 0; k < DWO; k++) begin
            rdata[k*DW +: DW] = mem[rp + DL'(k)];
        end
    end

endmodule

// File: rtl/common_sync_fifo_wc.sv
// Synchronous width-converting FIFO, DWI words in per beat, DWO words out per beat.
// Latency: one cycle from accepted input beat to visible output (first-word fall-through).
// Backpressure: s_ready from registered free space only; m_valid once DWO words are held.
module common_sync_fifo_wc
    import common_fifo_pkg::*;
#(
    parameter int unsigned DW     = 32,
    parameter int unsigned DWI    = 1,
    parameter int unsigned DWO    = 1,
    parameter int unsigned DL     = 2,
    parameter int unsigned AF_THR = (1 << DL) - DWI
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DW*DWI-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DW*DWO-1:0] m_data,
    input  logic              clr,
    output logic [DL:0]       occ,
    output logic [DL:0]       free,
    output logic              afull
);

    localparam int unsigned DEPTH = 1 << DL;

    // Catch illegal geometry at elaboration rather than producing a silently broken FIFO.
    if (!is_pow2(DWI)) begin : g_err_dwi
        $error("common_sync_fifo_wc: DWI must be a power of two");
    end
    if (!is_pow2(DWO)) begin : g_err_dwo
        $error("common_sync_fifo_wc: DWO must be a power of two");
    end
    if ((DEPTH < DWI) || (DEPTH < DWO)) begin : g_err_depth
        $error("common_sync_fifo_wc: 2**DL must be at least max(DWI, DWO)");
    end

    typedef struct packed {
        logic [DL:0] occ;
        logic [DL:0] free;
    } stat_t;

    localparam logic [DL:0]   DWI_W   = (DL+1)'(DWI);
    localparam logic [DL:0]   DWO_W   = (DL+1)'(DWO);
    localparam logic [DL:0]   DEPTH_W = (DL+1)'(DEPTH);
    localparam logic [DL:0]   ZERO_W  = '0;
    localparam logic [DL+1:0] AF_W    = (DL+2)'(AF_THR);
    localparam logic [DL-1:0] WP_STEP = DL'(DWI);
    localparam logic [DL-1:0] RP_STEP = DL'(DWO);

    stat_t         stat_q;
    stat_t         stat_d;
    logic          afull_q;
    logic          afull_d;
    logic [DL-1:0] wp;
    logic [DL-1:0] rp;
    logic          push;
    logic          pop;

    // Handshake decodes come straight off the registered counters, so no ready/valid loop exists.
    assign s_ready = (stat_q.free >= DWI_W);
    assign m_valid = (stat_q.occ >= DWO_W);
    assign push    = s_valid & s_ready & ~clr;
    assign pop     = m_valid & m_ready & ~clr;

    assign occ   = stat_q.occ;
    assign free  = stat_q.free;
    assign afull = afull_q;

    // Next occupancy: a flush wins, otherwise add pushed words and remove popped words together.
    always_comb begin
        stat_d = stat_q;
        if (clr) begin
            stat_d.occ = '0;
        end else begin
            stat_d.occ = stat_q.occ + (push ? DWI_W : ZERO_W) - (pop ? DWO_W : ZERO_W);
        end
        stat_d.free = DEPTH_W - stat_d.occ;
        afull_d     = ({1'b0, stat_d.occ} >= AF_W);
    end

    // Register occupancy, free space and the almost-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q.occ  <= '0;
            stat_q.free <= DEPTH_W;
            afull_q     <= (AF_THR == 0);
        end else begin
            stat_q  <= stat_d;
            afull_q <= afull_d;
        end
    end

    // Advance the pointers by a whole beat; wrap is free because beat sizes divide the depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else if (clr) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + WP_STEP;
            if (pop)  rp <= rp + RP_STEP;
        end
    end

    common_regfile_mw #(
        .DW  (DW),
        .DWI (DWI),
        .DWO (DWO),
        .DL  (DL)
    ) u_regfile (
        .clk   (clk),
        .we    (push),
        .wp    (wp),
        .wdata (s_data),
        .rp    (rp),
        .rdata (m_data)
    );

endmodule

// File: tb/tb_common_sync_fifo_wc.sv
module tb_common_sync_fifo_wc;

    logic clk = 1'b0;
    logic rst_n;

    // Instance A: 4 words in, 1 word out. Instance B: 1 word in, 4 words out.
    logic        a_s_valid, a_s_ready, a_m_valid, a_m_ready, a_clr, a_afull;
    logic [31:0] a_s_data;
    logic [7:0]  a_m_data;
    logic [3:0]  a_occ, a_free;

    logic        b_s_valid, b_s_ready, b_m_valid, b_m_ready, b_clr, b_afull;
    logic [7:0]  b_s_data;
    logic [31:0] b_m_data;
    logic [3:0]  b_occ, b_free;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;

    common_sync_fifo_wc #(.DW(8), .DWI(4), .DWO(1), .DL(3)) u_a (
        .clk(clk), .rst_n(rst_n),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data),
        .clr(a_clr), .occ(a_occ), .free(a_free), .afull(a_afull)
    );

    common_sync_fifo_wc #(.DW(8), .DWI(1), .DWO(4), .DL(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data),
        .clr(b_clr), .occ(b_occ), .free(b_free), .afull(b_afull)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each FIFO is a queue of words, 8 slots deep.
    bit ma_push, ma_pop, mb_push, mb_pop;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            ma_push = a_s_valid && ((8 - qa.size()) >= 4);
            ma_pop  = a_m_ready && (qa.size() >= 1);
            if (a_clr) qa.delete();
            else begin
                if (ma_pop) void'(qa.pop_front());
                if (ma_push) for (int k = 0; k < 4; k++) qa.push_back(a_s_data[k*8 +: 8]);
            end
            mb_push = b_s_valid && ((8 - qb.size()) >= 1);
            mb_pop  = b_m_ready && (qb.size() >= 4);
            if (b_clr) qb.delete();
            else begin
                if (mb_pop) for (int k = 0; k < 4; k++) void'(qb.pop_front());
                if (mb_push) qb.push_back(b_s_data);
            end
        end
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        chk("a_occ",    32'(a_occ),     32'(qa.size()));
        chk("a_free",   32'(a_free),    32'(8 - qa.size()));
        chk("a_sum",    32'(a_occ) + 32'(a_free), 32'd8);
        chk("a_sready", 32'(a_s_ready), 32'((8 - qa.size()) >= 4));
        chk("a_mvalid", 32'(a_m_valid), 32'(qa.size() >= 1));
        chk("a_afull",  32'(a_afull),   32'(qa.size() >= 4));
        if (qa.size() >= 1) chk("a_mdata", 32'(a_m_data), 32'(qa[0]));
        chk("b_occ",    32'(b_occ),     32'(qb.size()));
        chk("b_free",   32'(b_free),    32'(8 - qb.size()));
        chk("b_sum",    32'(b_occ) + 32'(b_free), 32'd8);
        chk("b_sready", 32'(b_s_ready), 32'((8 - qb.size()) >= 1));
        chk("b_mvalid", 32'(b_m_valid), 32'(qb.size() >= 4));
        chk("b_afull",  32'(b_afull),   32'(qb.size() >= 7));
        if (qb.size() >= 4) chk("b_mdata", b_m_data, {qb[3], qb[2], qb[1], qb[0]});
    end

    initial begin
        int a_in, a_out, b_in, b_out, cyc;
        bit acc_a, pop_a, acc_b, pop_b;
        rst_n = 1'b0;
        a_s_valid = 0; a_m_ready = 0; a_clr = 0; a_s_data = '0;
        b_s_valid = 0; b_m_ready = 0; b_clr = 0; b_s_data = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset mid-stream: leave rp at 1 and 3 words stored, then reset asynchronously.
        a_s_valid = 1; a_s_data = 32'h13121110;
        step();
        a_s_valid = 0; a_m_ready = 1;
        step();
        a_m_ready = 0;
        chk("pre_rst_occ", 32'(a_occ), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_occ",    32'(a_occ),     32'd0);
        chk("rst_free",   32'(a_free),    32'd8);
        chk("rst_sready", 32'(a_s_ready), 32'd1);
        chk("rst_mvalid", 32'(a_m_valid), 32'd0);
        chk("rst_afull",  32'(a_afull),   32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single 4-word push drained one word per cycle.
        a_s_valid = 1; a_s_data = 32'h03020100;
        step();
        a_s_valid = 0;
        chk("push_occ",    32'(a_occ),     32'd4);
        chk("push_mvalid", 32'(a_m_valid), 32'd1);
        a_m_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_mdata", 32'(a_m_data), 32'(i));
            step();
        end
        a_m_ready = 0;
        chk("drain_mvalid", 32'(a_m_valid), 32'd0);

        // Fill to full; a third beat waits until four words leave.
        a_s_valid = 1; a_s_data = 32'h23222120;
        step();
        a_s_data = 32'h27262524;
        step();
        a_s_data = 32'h2B2A2928;
        chk("full_occ",    32'(a_occ),     32'd8);
        chk("full_free",   32'(a_free),    32'd0);
        chk("full_sready", 32'(a_s_ready), 32'd0);
        chk("full_afull",  32'(a_afull),   32'd1);
        step();
        chk("full_hold_occ", 32'(a_occ), 32'd8);
        a_m_ready = 1;
        repeat (4) step();
        a_m_ready = 0;
        chk("refill_sready", 32'(a_s_ready), 32'd1);
        chk("refill_occ",    32'(a_occ),     32'd4);
        step();
        a_s_valid = 0;
        chk("refill_occ8", 32'(a_occ), 32'd8);
        a_m_ready = 1;
        for (int i = 0; i < 8; i++) begin
            chk("refill_mdata", 32'(a_m_data), 32'h24 + 32'(i));
            step();
        end
        a_m_ready = 0;
        chk("refill_empty", 32'(a_occ), 32'd0);

        // Simultaneous push and pop, then a flush that beats both.
        a_s_valid = 1; a_s_data = 32'h33323130;
        step();
        chk("sim_occ4", 32'(a_occ), 32'd4);
        a_s_data = 32'h37363534; a_m_ready = 1;
        step();
        chk("sim_occ7",  32'(a_occ),    32'd7);
        chk("sim_mdata", 32'(a_m_data), 32'h31);
        a_clr = 1; a_s_data = 32'h3B3A3938;
        step();
        a_clr = 0; a_s_valid = 0; a_m_ready = 0;
        chk("clr_occ",    32'(a_occ),     32'd0);
        chk("clr_free",   32'(a_free),    32'd8);
        chk("clr_mvalid", 32'(a_m_valid), 32'd0);
        a_s_valid = 1; a_s_data = 32'h43424140;
        step();
        a_s_valid = 0;
        chk("post_clr_mdata", 32'(a_m_data), 32'h40);
        chk("post_clr_occ",   32'(a_occ),    32'd4);
        a_m_ready = 1;
        repeat (4) step();
        a_m_ready = 0;

        // Narrow-to-wide: nothing valid until four words are held.
        b_s_valid = 1;
        b_s_data = 8'hA0; step();
        b_s_data = 8'hA1; step();
        b_s_data = 8'hA2; step();
        b_s_valid = 0;
        chk("b_part_mvalid", 32'(b_m_valid), 32'd0);
        chk("b_part_occ",    32'(b_occ),     32'd3);
        b_s_valid = 1; b_s_data = 8'hA3;
        step();
        b_s_valid = 0;
        chk("b_full_mvalid", 32'(b_m_valid), 32'd1);
        chk("b_full_mdata",  b_m_data,       32'hA3A2A1A0);
        b_m_ready = 1;
        step();
        b_m_ready = 0;

        // Random stream of 200 words through each instance.
        a_in = 0; a_out = 0; b_in = 0; b_out = 0; cyc = 0;
        while ((a_out < 200 || b_out < 200) && cyc < 5000) begin
            if (!a_s_valid && a_in < 200 && $urandom_range(0, 3) != 0) begin
                a_s_valid = 1;
                a_s_data = {8'(a_in + 3), 8'(a_in + 2), 8'(a_in + 1), 8'(a_in)};
            end
            if (!b_s_valid && b_in < 200 && $urandom_range(0, 3) != 0) begin
                b_s_valid = 1;
                b_s_data = 8'(b_in + 8'h55);
            end
            a_m_ready = ($urandom_range(0, 3) != 0);
            b_m_ready = ($urandom_range(0, 3) != 0);
            acc_a = a_s_valid && a_s_ready;
            pop_a = a_m_valid && a_m_ready;
            acc_b = b_s_valid && b_s_ready;
            pop_b = b_m_valid && b_m_ready;
            step();
            cyc++;
            if (acc_a) begin a_in += 4; a_s_valid = 0; end
            if (pop_a) a_out += 1;
            if (acc_b) begin b_in += 1; b_s_valid = 0; end
            if (pop_b) b_out += 4;
        end
        a_s_valid = 0; a_m_ready = 0; b_s_valid = 0; b_m_ready = 0;
        chk("stream_a_out", 32'(a_out), 32'd200);
        chk("stream_b_out", 32'(b_out), 32'd200);
        chk("stream_a_occ", 32'(a_occ), 32'd0);
        chk("stream_b_occ", 32'(b_occ), 32'd0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
